encoder_8_3_queued: RTL and testbench
=====================================

# encoder_8_3_queued

Registered 8-to-3 request encoder with pending-event storage and a valid/ready output handshake. It is the companion of the 3-to-8 one-hot decoder: it collects up to eight event/request lines and returns each one, in fixed priority order, as a 3-bit binary code. It sits between raw request sources such as buttons, interrupt lines or FSM flags and a consumer that handles one code at a time.

## Interface
Parameters: none. Width is fixed at 8 request lines and a 3-bit code.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- insig  input  8  request lines, sampled every cycle; bit i high = one event for code i
- outsig  output  3  binary code of the presented request; registered
- out_valid  output  1  outsig holds an undelivered code; registered
- out_ready  input  1  consumer accepts outsig this cycle when out_valid=1
- pending  output  8  requests stored but not yet presented; registered
- ovf  output  1  sticky: an event was lost (merged into an already-pending bit)
- ovf_clr  input  1  clears ovf

## Operation
- The output stage has two states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- Combinational terms:
  - cand = pending | insig
  - free = !out_valid | out_ready
- Load: if free and cand≠0, then:
  - outsig ← index of the highest set bit of cand (bit 7 highest, bit 0 lowest).
  - out_valid ← 1.
  - That bit is removed from pending: pending ← cand & ~onehot(outsig_next).
- No load: pending ← cand. out_valid ← 0 if out_ready was accepting, otherwise it stays.
- FULL→EMPTY: accept (out_valid & out_ready) with cand=0.
- FULL→FULL: accept with cand≠0 (back-to-back load), or no accept (hold).
- EMPTY→FULL: cand≠0.
- While FULL and out_ready=0, outsig and out_valid are stable. The consumer always sees a stable code until it accepts it.
- When out_valid=0, outsig retains its last value. It is not guaranteed meaningful.
- insig is level-sampled. A line held high for k cycles is k events.
- Bit currently presented on outsig is re-asserted on insig: it becomes pending as a new event. This is not an overflow.
- insig[i] is high while pending[i]=1 (before the load decision): ovf ← 1. The events merge and only one is delivered.
- A bit in cand that is loaded this cycle is never also left in pending.
- ovf_clr=1 clears ovf, except that a new overflow in the same cycle takes precedence: ovf stays 1.
- Arithmetic: the code is a pure priority index, 0..7. There are no counters and no wrap-around.

## Timing
- Reset (rst=1 at a rising edge): pending=8'h00, outsig=3'd0, out_valid=0, ovf=0. insig in the reset cycle is discarded.
- Reset mid-operation discards all pending and presented codes with no partial delivery.
- Latency: insig[i] high in cycle N with the output free gives out_valid=1, outsig=i in cycle N+1.
- Throughput: with out_ready held high, one code per cycle. There are no bubbles between back-to-back codes.
- Accept and new request in the same cycle: the accepted code leaves, and the next cand winner appears in the next cycle.
- Under backpressure, lower-priority requests wait. A higher-priority request arriving later does not displace a code already presented.

## Test plan
- Reset: drive insig=8'hFF and rst=1 for 2 cycles, then rst=0 with insig=0. Required: out_valid=0, outsig=0, pending=0, ovf=0.
- Single event: insig=8'b00000100 for 1 cycle, out_ready=1. Required: next cycle out_valid=1, outsig=2. The cycle after: out_valid=0, pending=0.
- Priority burst: insig=8'b10010010 for 1 cycle, out_ready=1. Required: outsig=7, 4, 1 on three consecutive cycles, each with out_valid=1, then out_valid=0.
- Backpressure: out_ready=0. insig=8'b00000001 in cycle 0, then 8'b10000000 in cycle 1. Required: outsig=0 with out_valid=1 held stable for 5 cycles and pending=8'h80. Raise out_ready: outsig=0 is accepted, then outsig=7 appears the next cycle.
- Overflow: out_ready=0 with code 0 held. Pulse insig[3] twice, 2 cycles apart. Required: ovf=1 and pending=8'h08. Pulse ovf_clr: ovf=0. Release out_ready: code 3 is delivered exactly once after code 0.
- Reset mid-operation: reach pending=8'hFE with out_valid=1, then assert rst for 1 cycle. Required: the next cycle has all outputs at reset values, and no stale code is delivered afterward.

Source files
------------

// File: rtl/encoder_8_3_queued.sv
// rtl/encoder_8_3_queued.sv - 8-to-3 priority request encoder with pending store and valid/ready output
module encoder_8_3_queued (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] insig,
  output logic [2:0] outsig,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] pending,
  output logic       ovf,
  input  logic       ovf_clr
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t     state, state_next;
  logic [7:0] cand;
  logic [7:0] win_onehot;
  logic [7:0] pending_next;
  logic [2:0] win;
  logic [2:0] outsig_next;
  logic       free;
  logic       load;
  logic       ovf_next;

  always_comb begin
    cand = pending | insig;
    free = (state == EMPTY) | out_ready;
    load = free & (|cand);
  end

  // Ascending scan: the last set bit seen is the highest, so it wins.
  always_comb begin
    win = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (cand[i]) win = 3'(i);
    end
    win_onehot = 8'b0000_0001 << win;
  end

  always_comb begin
    state_next   = state;
    outsig_next  = outsig;
    pending_next = cand;
    if (load) begin
      state_next   = FULL;
      outsig_next  = win;
      pending_next = cand & ~win_onehot;
    end else if ((state == FULL) && out_ready) begin
      state_next = EMPTY;
    end
  end

  // A fresh collision beats a clear issued in the same cycle.
  always_comb begin
    ovf_next = ovf;
    if (|(insig & pending)) ovf_next = 1'b1;
    else if (ovf_clr)       ovf_next = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= EMPTY;
      outsig  <= 3'd0;
      pending <= 8'h00;
      ovf     <= 1'b0;
    end else begin
      state   <= state_next;
      outsig  <= outsig_next;
      pending <= pending_next;
      ovf     <= ovf_next;
    end
  end

  assign out_valid = (state == FULL);

endmodule

// File: tb/tb_encoder_8_3_queued.sv
// tb/tb_encoder_8_3_queued.sv - table-driven and scoreboard bench for encoder_8_3_queued
module tb_encoder_8_3_queued;

  logic       clk;
  logic       rst;
  logic [7:0] insig;
  logic [2:0] outsig;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] pending;
  logic       ovf;
  logic       ovf_clr;

  encoder_8_3_queued dut (
    .clk       (clk),
    .rst       (rst),
    .insig     (insig),
    .outsig    (outsig),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pending   (pending),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [7:0] insig;
    logic       rdy;
    logic       clr;
    logic       v;
    logic [2:0] code;
    logic [7:0] pend;
    logic       o;
  } vec_t;

  vec_t       vt[$];
  logic [2:0] exp_q[$];
  int         n_vec = 0;
  int         n_bad = 0;
  logic       sb_on = 1'b0;

  task automatic add(input logic r, input logic [7:0] i, input logic rd, input logic c,
                     input logic v, input logic [2:0] code, input logic [7:0] p, input logic o);
    vec_t e;
    e.rst = r; e.insig = i; e.rdy = rd; e.clr = c;
    e.v = v; e.code = code; e.pend = p; e.o = o;
    vt.push_back(e);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every accepted code must match the oldest expected one.
  always @(negedge clk) begin
    if (sb_on && !rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_code", {5'd0, outsig}, 8'hEE);
      end else begin
        check("sb_code", {5'd0, outsig}, {5'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    logic [7:0] m;
    int         budget;

    rst = 1'b1; insig = 8'hFF; out_ready = 1'b1; ovf_clr = 1'b0;

    //  rst  insig  rdy clr   v  code  pend   o
    add(1, 8'hFF, 1, 0,  0, 3'd0, 8'h00, 0);   // reset, insig discarded
    add(1, 8'hFF, 1, 0,  0, 3'd0, 8'h00, 0);
    add(0, 8'h00, 1, 0,  0, 3'd0, 8'h00, 0);
    add(0, 8'h04, 1, 0,  1, 3'd2, 8'h00, 0);   // single event
    add(0, 8'h00, 1, 0,  0, 3'd2, 8'h00, 0);
    add(0, 8'h92, 1, 0,  1, 3'd7, 8'h12, 0);   // priority burst
    add(0, 8'h00, 1, 0,  1, 3'd4, 8'h02, 0);
    add(0, 8'h00, 1, 0,  1, 3'd1, 8'h00, 0);
    add(0, 8'h00, 1, 0,  0, 3'd1, 8'h00, 0);
    add(0, 8'h01, 0, 0,  1, 3'd0, 8'h00, 0);   // backpressure
    add(0, 8'h80, 0, 0,  1, 3'd0, 8'h80, 0);
    add(0, 8'h00, 0, 0,  1, 3'd0, 8'h80, 0);
    add(0, 8'h00, 0, 0,  1, 3'd0, 8'h80, 0);
    add(0, 8'h00, 0, 0,  1, 3'd0, 8'h80, 0);
    add(0, 8'h00, 0, 0,  1, 3'd0, 8'h80, 0);
    add(0, 8'h00, 1, 0,  1, 3'd7, 8'h00, 0);
    add(0, 8'h00, 1, 0,  0, 3'd7, 8'h00, 0);
    add(0, 8'h01, 0, 0,  1, 3'd0, 8'h00, 0);   // overflow
    add(0, 8'h08, 0, 0,  1, 3'd0, 8'h08, 0);
    add(0, 8'h00, 0, 0,  1, 3'd0, 8'h08, 0);
    add(0, 8'h08, 0, 0,  1, 3'd0, 8'h08, 1);
    add(0, 8'h00, 0, 1,  1, 3'd0, 8'h08, 0);
    add(0, 8'h00, 1, 0,  1, 3'd3, 8'h00, 0);
    add(0, 8'h00, 1, 0,  0, 3'd3, 8'h00, 0);
    add(0, 8'h20, 0, 0,  1, 3'd5, 8'h00, 0);   // re-assert presented bit
    add(0, 8'h20, 0, 0,  1, 3'd5, 8'h20, 0);
    add(0, 8'h00, 1, 0,  1, 3'd5, 8'h00, 0);
    add(0, 8'h00, 1, 0,  0, 3'd5, 8'h00, 0);
    add(0, 8'h02, 0, 0,  1, 3'd1, 8'h00, 0);   // clear vs new overflow
    add(0, 8'h02, 0, 0,  1, 3'd1, 8'h02, 0);
    add(0, 8'h02, 0, 1,  1, 3'd1, 8'h02, 1);
    add(0, 8'h00, 1, 0,  1, 3'd1, 8'h00, 1);
    add(0, 8'h00, 1, 1,  0, 3'd1, 8'h00, 0);
    add(0, 8'h01, 0, 0,  1, 3'd0, 8'h00, 0);   // reset mid-operation
    add(0, 8'hFE, 0, 0,  1, 3'd0, 8'hFE, 0);
    add(1, 8'h00, 0, 0,  0, 3'd0, 8'h00, 0);
    add(0, 8'h00, 1, 0,  0, 3'd0, 8'h00, 0);
    add(0, 8'h00, 1, 0,  0, 3'd0, 8'h00, 0);

    for (int k = 0; k < vt.size(); k++) begin
      rst = vt[k].rst; insig = vt[k].insig; out_ready = vt[k].rdy; ovf_clr = vt[k].clr;
      @(posedge clk);
      #1;
      check($sformatf("row%0d_valid", k), {7'd0, out_valid}, {7'd0, vt[k].v});
      check($sformatf("row%0d_code", k), {5'd0, outsig}, {5'd0, vt[k].code});
      check($sformatf("row%0d_pending", k), pending, vt[k].pend);
      check($sformatf("row%0d_ovf", k), {7'd0, ovf}, {7'd0, vt[k].o});
    end

    rst = 1'b0; ovf_clr = 1'b0; insig = 8'h00; out_ready = 1'b0;
    sb_on = 1'b1;
    for (int t = 0; t < 12; t++) begin
      m = 8'($urandom_range(1, 255));
      for (int b = 7; b >= 0; b--) begin
        if (m[b]) exp_q.push_back(3'(b));
      end
      insig = m;
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      insig = 8'h00;
      budget = 0;
      while (exp_q.size() != 0 && budget < 200) begin
        out_ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        budget++;
      end
      if (exp_q.size() != 0) begin
        check("sb_timeout_left", 8'(exp_q.size()), 8'd0);
        exp_q.delete();
      end
    end
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    sb_on = 1'b0;
    check("sb_final_valid", {7'd0, out_valid}, 8'd0);
    check("sb_final_pending", pending, 8'h00);
    check("sb_final_ovf", {7'd0, ovf}, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
